// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU (shift stage + execute/result register) with a persistent NZCV flag register.
// Optional macro ALU_PIPE_ITER_MUL_EN selects a WIDTH-cycle shift-add multiplier instead of a combinational one.
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [31:0]      inf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             wr_en,
  output logic             n,
  output logic             z,
  output logic             c,
  output logic             v
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_ORR  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_EOR  = 4'd5;
  localparam logic [3:0] OP_MOVN = 4'd6;
  localparam logic [3:0] OP_MOV  = 4'd7;
  localparam logic [3:0] OP_CMP  = 4'd8;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] op1_q, op1_d, op2_q, op2_d;
  logic [3:0]       cond_q, cond_d, opc_q, opc_d;
  logic             s_q, s_d;
  logic [15:0]      imm_q, imm_d;

  logic             out_valid_q, out_valid_d, wr_en_q, wr_en_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d;

  logic             out_can_load, s1_adv, accept, s2_done, cond_pass;
  logic [WIDTH-1:0] a_sh, mul_res, alu_val;
  logic [31:0]      sh_amt, rot_amt;
  logic [WIDTH:0]   sum, dif;
  logic             alu_wr, has_flags, upd_cv, c_new, v_new;
  logic             unused_inf;

  assign unused_inf = ^inf[22:19];

  always_comb begin
    sh_amt  = {27'd0, inf[10:6]};
    rot_amt = sh_amt % 32'(WIDTH);
    case (inf[2:0])
      3'b010:  a_sh = (sh_amt >= 32'(WIDTH)) ? '0 : (a << sh_amt);
      3'b001:  a_sh = (sh_amt >= 32'(WIDTH)) ? '0 : (a >> sh_amt);
      3'b011:  a_sh = (a >> rot_amt) | (a << (32'(WIDTH) - rot_amt));
      default: a_sh = a;
    endcase
  end

  always_comb begin
    case (cond_q)
      4'h0: cond_pass = z_q;
      4'h1: cond_pass = !z_q;
      4'h2: cond_pass = c_q;
      4'h3: cond_pass = !c_q;
      4'h4: cond_pass = n_q;
      4'h5: cond_pass = !n_q;
      4'h6: cond_pass = v_q;
      4'h7: cond_pass = !v_q;
      4'h8: cond_pass = c_q && !z_q;
      4'h9: cond_pass = !c_q || z_q;
      4'hA: cond_pass = (n_q == v_q);
      4'hB: cond_pass = (n_q != v_q);
      4'hC: cond_pass = !z_q && (n_q == v_q);
      4'hD: cond_pass = z_q || (n_q != v_q);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

`ifdef ALU_PIPE_ITER_MUL_EN
  localparam int CW = $clog2(WIDTH);
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             mul_busy;

  // The last partial product is folded in combinationally on the load edge, so the
  // counter only has to step WIDTH-1 times before the result can be written.
  assign mul_busy = s1_valid_q && (opc_q == OP_MUL) && cond_pass && (cnt_q != CW'(WIDTH - 1));
  assign mul_res  = acc_q + (op2_q[WIDTH-1] ? (op1_q << (WIDTH - 1)) : '0);
  assign s2_done  = !mul_busy;

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    if (s1_adv) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (mul_busy) begin
      cnt_d = cnt_q + 1'b1;
      if (op2_q[cnt_q]) acc_d = acc_q + (op1_q << cnt_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end
`else
  assign mul_res = op1_q * op2_q;
  assign s2_done = 1'b1;
`endif

  always_comb begin
    sum       = {1'b0, op1_q} + {1'b0, op2_q};
    dif       = {1'b0, op1_q} - {1'b0, op2_q};
    alu_val   = '0;
    alu_wr    = 1'b0;
    has_flags = 1'b1;
    upd_cv    = 1'b0;
    c_new     = c_q;
    v_new     = v_q;
    case (opc_q)
      OP_ADD: begin
        alu_val = sum[WIDTH-1:0];
        alu_wr  = 1'b1;
        upd_cv  = 1'b1;
        c_new   = sum[WIDTH];
        v_new   = (op1_q[WIDTH-1] == op2_q[WIDTH-1]) && (sum[WIDTH-1] != op1_q[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        alu_val = dif[WIDTH-1:0];
        alu_wr  = (opc_q == OP_SUB);
        upd_cv  = 1'b1;
        c_new   = !dif[WIDTH];
        v_new   = (op1_q[WIDTH-1] != op2_q[WIDTH-1]) && (dif[WIDTH-1] != op1_q[WIDTH-1]);
      end
      OP_MUL:  begin alu_val = mul_res;             alu_wr = 1'b1; end
      OP_ORR:  begin alu_val = op1_q | op2_q;       alu_wr = 1'b1; end
      OP_AND:  begin alu_val = op1_q & op2_q;       alu_wr = 1'b1; end
      OP_EOR:  begin alu_val = op1_q ^ op2_q;       alu_wr = 1'b1; end
      OP_MOVN: begin alu_val = WIDTH'(imm_q);       alu_wr = 1'b1; end
      OP_MOV:  begin alu_val = op1_q;               alu_wr = 1'b1; end
      default: has_flags = 1'b0;
    endcase
  end

  assign out_can_load = !out_valid_q || out_ready;
  assign s1_adv       = s1_valid_q && s2_done && out_can_load;
  assign in_ready     = !s1_valid_q || s1_adv;
  assign accept       = in_valid && in_ready;

  always_comb begin
    s1_valid_d = accept || (s1_valid_q && !s1_adv);
    op1_d  = accept ? a_sh       : op1_q;
    op2_d  = accept ? b          : op2_q;
    cond_d = accept ? inf[31:28] : cond_q;
    opc_d  = accept ? inf[27:24] : opc_q;
    s_d    = accept ? inf[23]    : s_q;
    imm_d  = accept ? inf[18:3]  : imm_q;

    out_valid_d = out_valid_q;
    r_d         = r_q;
    wr_en_d     = wr_en_q;
    n_d = n_q;
    z_d = z_q;
    c_d = c_q;
    v_d = v_q;
    if (s1_adv) begin
      out_valid_d = 1'b1;
      wr_en_d     = cond_pass && alu_wr;
      r_d         = (cond_pass && alu_wr) ? alu_val : '0;
      // Flags land on the same edge as the result, so the next op in S1 sees them without a bubble.
      if (cond_pass && has_flags && (s_q || opc_q == OP_CMP)) begin
        n_d = alu_val[WIDTH-1];
        z_d = (alu_val == '0);
        if (upd_cv) begin
          c_d = c_new;
          v_d = v_new;
        end
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      cond_q      <= '0;
      opc_q       <= '0;
      s_q         <= 1'b0;
      imm_q       <= '0;
      out_valid_q <= 1'b0;
      r_q         <= '0;
      wr_en_q     <= 1'b0;
      n_q <= 1'b0;
      z_q <= 1'b0;
      c_q <= 1'b0;
      v_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      cond_q      <= cond_d;
      opc_q       <= opc_d;
      s_q         <= s_d;
      imm_q       <= imm_d;
      out_valid_q <= out_valid_d;
      r_q         <= r_d;
      wr_en_q     <= wr_en_d;
      n_q <= n_d;
      z_q <= z_d;
      c_q <= c_d;
      v_q <= v_d;
    end
  end

  assign out_valid = out_valid_q;
  assign r         = r_q;
  assign wr_en     = wr_en_q;
  assign n = n_q;
  assign z = z_q;
  assign c = c_q;
  assign v = v_q;

endmodule
